// File: rtl/size_patch_writer.sv
// Size-patch consumer: queues (offset, value, size) requests and writes each value
// big-endian, one byte per granted cycle, into the shared bitstream memory port.
module size_patch_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [31:0]      offset_addr,
  input  logic [31:0]      val,
  input  logic [31:0]      byte_size,
  input  logic             mem_grant,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [7:0]       mem_wdata,
  output logic             busy,
  output logic             overflow,
  output logic             bad_size,
  output logic [CNT_W-1:0] patch_done_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = FIFO_DEPTH[PTR_W:0];

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] val;
    logic [2:0]  size;
  } entry_t;

  typedef enum logic {IDLE, WRITE} state_t;

  // Selects byte i of an n-byte big-endian field (byte 0 is the most significant).
  function automatic logic [7:0] byte_of(input logic [31:0] v, input logic [2:0] n,
                                         input logic [2:0] i);
    logic [2:0]  sh;
    logic [31:0] s;
    sh = n - 3'd1 - i;
    s  = v >> {sh[1:0], 3'b000};
    return s[7:0];
  endfunction

  state_t           state_q, state_d;
  entry_t           fifo_mem [FIFO_DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      val_q, addr_q;
  logic [2:0]       n_q;
  logic [1:0]       idx_q;
  logic [7:0]       wdata_q;
  logic [CNT_W-1:0] done_q;
  logic             overflow_q, bad_size_q;
  logic             req_legal, req_illegal, push, pop, last;

  assign req_legal   = (byte_size != 32'd0) && (byte_size <= 32'd4);
  assign req_illegal = (byte_size > 32'd4);
  assign pop         = (state_q == IDLE) && (count_q != '0);
  // A full FIFO still accepts when the head is being popped on the same edge.
  assign push        = req_legal && ((count_q != DEPTH_C) || pop);
  assign head        = fifo_mem[rd_ptr_q];
  assign last        = ({1'b0, idx_q} == (n_q - 3'd1));

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: queue storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= '{addr: offset_addr, val: val, size: byte_size[2:0]};
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      bad_size_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (req_legal && !push) overflow_q <= 1'b1;
      if (req_illegal)        bad_size_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = WRITE;
      WRITE:   if (mem_we && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_we = (state_q == WRITE) && mem_grant;
    busy   = (state_q != IDLE) || (count_q != '0);
  end

  // Address and data are registered so they never glitch while the strobe is high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      val_q   <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= '0;
    end else if (pop) begin
      val_q   <= head.val;
      n_q     <= head.size;
      idx_q   <= '0;
      addr_q  <= head.addr;
      wdata_q <= byte_of(head.val, head.size, 3'd0);
    end else if (mem_we) begin
      idx_q   <= idx_q + 2'd1;
      addr_q  <= addr_q + 32'd1;
      wdata_q <= byte_of(val_q, n_q, {1'b0, idx_q} + 3'd1);
      if (last) done_q <= done_q + 1'b1;
    end
  end

  assign mem_addr         = addr_q;
  assign mem_wdata        = wdata_q;
  assign overflow         = overflow_q;
  assign bad_size         = bad_size_q;
  assign patch_done_count = done_q;

endmodule
